// File: rtl/mux4_rr_scheduler.sv
// Four-input round-robin scheduler with a single registered output slot.
// A winner is captured into y/s with a one-cycle gnt pulse; the slot drains when out_ready is high.
module mux4_rr_scheduler #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    input  logic             out_ready,
    output logic [3:0]       gnt,
    output logic [1:0]       s,
    output logic [WIDTH-1:0] y,
    output logic             out_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       ptr;
    logic [3:0]       eligible;
    logic             any_eligible;
    logic [1:0]       winner;
    logic [1:0]       cand;
    logic             found;
    logic             capture;
    logic             drain;
    logic [WIDTH-1:0] win_data;

    // A requester that is seeing its grant this cycle still shows stale req/data.
    assign eligible     = req & ~gnt;
    assign any_eligible = |eligible;

    always_comb begin
        winner = ptr;
        found  = 1'b0;
        cand   = ptr;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && eligible[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        win_data = I0;
        case (winner)
            2'd0:    win_data = I0;
            2'd1:    win_data = I1;
            2'd2:    win_data = I2;
            default: win_data = I3;
        endcase
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        drain      = 1'b0;
        case (state)
            IDLE: begin
                if (any_eligible) begin
                    capture    = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (out_ready) begin
                    if (any_eligible) begin
                        capture = 1'b1;
                    end else begin
                        drain      = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // gnt falls back to zero every cycle so it is only ever a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            s         <= 2'd0;
            y         <= '0;
            gnt       <= 4'b0000;
            out_valid <= 1'b0;
        end else begin
            state <= state_next;
            gnt   <= 4'b0000;
            if (capture) begin
                y         <= win_data;
                s         <= winner;
                gnt       <= 4'b0001 << winner;
                out_valid <= 1'b1;
                ptr       <= winner + 2'd1;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Self-checking bench for mux4_rr_scheduler: vector table plus stale-grant and starvation sequences.
module tb_mux4_rr_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] I0, I1, I2, I3;
    logic       out_ready;
    logic [3:0] gnt;
    logic [1:0] s;
    logic [3:0] y;
    logic       out_valid;

    int checks;
    int errors;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rdy;
        logic [3:0] e_gnt;
        logic [1:0] e_s;
        logic [3:0] e_y;
        logic       e_ov;
    } vec_t;

    vec_t vecs[19];

    mux4_rr_scheduler #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .I0        (I0),
        .I1        (I1),
        .I2        (I2),
        .I3        (I3),
        .out_ready (out_ready),
        .gnt       (gnt),
        .s         (s),
        .y         (y),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic rdy);
        rst       = r;
        req       = rq;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    int cap_num;
    int counts[4];
    int last_seen[4];
    int max_gap;
    int gnt_pulses;
    int cmin, cmax;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; req = 4'b0000; out_ready = 1'b0;
        I0 = 4'hA; I1 = 4'hF; I2 = 4'hC; I3 = 4'hE;

        // rst, req, rdy, gnt, s, y, out_valid
        vecs[0]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'h0, 1'b0};
        vecs[1]  = '{1'b0, 4'b0010, 1'b1, 4'b0010, 2'd1, 4'hF, 1'b1};
        vecs[2]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd1, 4'hF, 1'b0};
        vecs[3]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'h0, 1'b0};
        vecs[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 4'hA, 1'b1};
        vecs[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 4'hF, 1'b1};
        vecs[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 2'd2, 4'hC, 1'b1};
        vecs[7]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 2'd3, 4'hE, 1'b1};
        vecs[8]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 4'hA, 1'b1};
        vecs[9]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'h0, 1'b0};
        vecs[10] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 4'hC, 1'b1};
        vecs[11] = '{1'b0, 4'b1011, 1'b0, 4'b0000, 2'd2, 4'hC, 1'b1};
        vecs[12] = '{1'b0, 4'b1011, 1'b0, 4'b0000, 2'd2, 4'hC, 1'b1};
        vecs[13] = '{1'b0, 4'b1011, 1'b0, 4'b0000, 2'd2, 4'hC, 1'b1};
        vecs[14] = '{1'b0, 4'b1011, 1'b0, 4'b0000, 2'd2, 4'hC, 1'b1};
        vecs[15] = '{1'b0, 4'b1011, 1'b0, 4'b0000, 2'd2, 4'hC, 1'b1};
        vecs[16] = '{1'b0, 4'b1011, 1'b1, 4'b1000, 2'd3, 4'hE, 1'b1};
        vecs[17] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 4'h0, 1'b0};
        vecs[18] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 4'hA, 1'b1};

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].rdy);
            checkOutput($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].e_gnt));
            checkOutput($sformatf("v%0d_s", i), 32'(s), 32'(vecs[i].e_s));
            checkOutput($sformatf("v%0d_y", i), 32'(y), 32'(vecs[i].e_y));
            checkOutput($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
        end

        // Stale-grant guard: req[0] held one cycle past its grant.
        applyStimulus(1'b1, 4'b0000, 1'b1);
        gnt_pulses = 0;
        applyStimulus(1'b0, 4'b0001, 1'b1);
        if (gnt != 4'b0000) gnt_pulses++;
        checkOutput("stale_first_gnt", 32'(gnt), 32'h1);
        applyStimulus(1'b0, 4'b0001, 1'b1);
        if (gnt != 4'b0000) gnt_pulses++;
        checkOutput("stale_second_gnt", 32'(gnt), 32'h0);
        checkOutput("stale_valid_drop", 32'(out_valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'b0000, 1'b1);
            if (gnt != 4'b0000) gnt_pulses++;
        end
        checkOutput("stale_capture_count", 32'(gnt_pulses), 32'd1);
        checkOutput("stale_valid_end", 32'(out_valid), 32'h0);

        // Starvation: all requesting, random backpressure.
        applyStimulus(1'b1, 4'b0000, 1'b1);
        cap_num = 0;
        for (int i = 0; i < 4; i++) begin
            counts[i]    = 0;
            last_seen[i] = 0;
        end
        for (int c = 0; c < 400; c++) begin
            applyStimulus(1'b0, 4'b1111, 1'($urandom_range(0, 1)));
            if (gnt != 4'b0000) begin
                checkOutput("starve_onehot", 32'($countones(gnt)), 32'd1);
                checkOutput("starve_gnt_vs_s", 32'(gnt), 32'(4'b0001 << s));
                cap_num++;
                counts[s]++;
                last_seen[s] = cap_num;
                if (cap_num >= 4) begin
                    max_gap = 0;
                    for (int i = 0; i < 4; i++)
                        if (cap_num - last_seen[i] > max_gap) max_gap = cap_num - last_seen[i];
                    checkOutput("starve_window", 32'(max_gap <= 3), 32'd1);
                end
            end
        end
        cmin = counts[0];
        cmax = counts[0];
        for (int i = 1; i < 4; i++) begin
            if (counts[i] < cmin) cmin = counts[i];
            if (counts[i] > cmax) cmax = counts[i];
        end
        checkOutput("starve_enough_captures", 32'(cap_num >= 50), 32'd1);
        checkOutput("starve_balance", 32'(cmax - cmin <= 1), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
